// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The controller drives the control lines (master); the datapath supplies instruction fields and the zero flag.
interface multi_cycle_ctrl_if;
    logic [6:0] i_op;
    logic [2:0] i_funct3;
    logic       i_funct7b5;
    logic       i_zero;
    logic       o_pcWrite;
    logic       o_adrSrc;
    logic       o_memWrite;
    logic       o_irWrite;
    logic       o_regWrite;
    logic [1:0] o_resultSrc;
    logic [1:0] o_aluSrcA;
    logic [1:0] o_aluSrcB;
    logic [2:0] o_aluControl;
    logic [1:0] o_immSrc;
    logic [3:0] o_state;

    modport master (
        input  i_op, i_funct3, i_funct7b5, i_zero,
        output o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite,
               o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluControl, o_immSrc, o_state
    );

    modport slave (
        output i_op, i_funct3, i_funct7b5, i_zero,
        input  o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite,
               o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluControl, o_immSrc, o_state
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM of the multi-cycle RV32I core, with ALU decoder, immediate-select decoder and branch logic.
module multi_cycle_ctrl (
    input  logic               i_clk,
    input  logic               i_arst,
    multi_cycle_ctrl_if.master bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    logic [3:0] state;
    logic [3:0] state_next;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (bus.i_op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = (bus.i_op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            JAL:      state_next = ALUWB;
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        pc_update           = 1'b0;
        branch              = 1'b0;
        ir_write            = 1'b0;
        reg_write           = 1'b0;
        mem_write           = 1'b0;
        alu_op              = 2'b00;
        bus.o_adrSrc        = 1'b0;
        bus.o_resultSrc     = 2'b00;
        bus.o_aluSrcA       = 2'b00;
        bus.o_aluSrcB       = 2'b00;
        case (state)
            FETCH: begin
                ir_write        = 1'b1;
                pc_update       = 1'b1;
                bus.o_aluSrcB   = 2'b10;
                bus.o_resultSrc = 2'b10;
            end
            DECODE: begin
                bus.o_aluSrcA = 2'b01;
                bus.o_aluSrcB = 2'b01;
            end
            MEMADR: begin
                bus.o_aluSrcA = 2'b10;
                bus.o_aluSrcB = 2'b01;
            end
            MEMREAD:  bus.o_adrSrc = 1'b1;
            MEMWB: begin
                bus.o_resultSrc = 2'b01;
                reg_write       = 1'b1;
            end
            MEMWRITE: begin
                bus.o_adrSrc = 1'b1;
                mem_write    = 1'b1;
            end
            EXECR: begin
                bus.o_aluSrcA = 2'b10;
                alu_op        = 2'b10;
            end
            EXECI: begin
                bus.o_aluSrcA = 2'b10;
                bus.o_aluSrcB = 2'b01;
                alu_op        = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                bus.o_aluSrcA = 2'b10;
                alu_op        = 2'b01;
                branch        = 1'b1;
            end
            JAL: begin
                bus.o_aluSrcA = 2'b01;
                bus.o_aluSrcB = 2'b10;
                pc_update     = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are gated by reset so an aborted instruction never commits anything.
    always_comb begin
        bus.o_pcWrite  = (pc_update | (branch & bus.i_zero)) & ~i_arst;
        bus.o_irWrite  = ir_write & ~i_arst;
        bus.o_regWrite = reg_write & ~i_arst;
        bus.o_memWrite = mem_write & ~i_arst;
        bus.o_state    = state;
    end

    always_comb begin
        bus.o_aluControl = ALU_ADD;
        case (alu_op)
            2'b01: bus.o_aluControl = ALU_SUB;
            2'b10: begin
                case (bus.i_funct3)
                    3'b000:  bus.o_aluControl = (bus.i_op[5] & bus.i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  bus.o_aluControl = ALU_SLT;
                    3'b110:  bus.o_aluControl = ALU_OR;
                    3'b111:  bus.o_aluControl = ALU_AND;
                    default: bus.o_aluControl = ALU_ADD;
                endcase
            end
            default: bus.o_aluControl = ALU_ADD;
        endcase
    end

    always_comb begin
        case (bus.i_op)
            OP_SW:   bus.o_immSrc = 2'b01;
            OP_BEQ:  bus.o_immSrc = 2'b10;
            OP_JAL:  bus.o_immSrc = 2'b11;
            default: bus.o_immSrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: directed instructions push per-cycle expected
// control words, and an independent monitor compares them on each falling edge.
module tb_multi_cycle_ctrl;
    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] imm_src;
    } ctrl_t;

    typedef struct {
        string tag;
        ctrl_t exp;
    } entry_t;

    logic   clk;
    logic   rst;
    entry_t scoreboard[$];
    int     checks;
    int     errors;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .i_clk  (clk),
        .i_arst (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Hand-written table of the control word each state must present.
    function automatic ctrl_t expected_word(input logic [3:0] st, input logic [2:0] exec_alu,
                                            input logic beq_taken, input logic [1:0] imm);
        ctrl_t w;
        w = '0;
        w.state   = st;
        w.imm_src = imm;
        case (st)
            4'd0: begin w.pc_write = 1; w.ir_write = 1; w.result_src = 2'b10; w.alu_src_b = 2'b10; end
            4'd1: begin w.alu_src_a = 2'b01; w.alu_src_b = 2'b01; end
            4'd2: begin w.alu_src_a = 2'b10; w.alu_src_b = 2'b01; end
            4'd3: begin w.adr_src = 1; end
            4'd4: begin w.result_src = 2'b01; w.reg_write = 1; end
            4'd5: begin w.adr_src = 1; w.mem_write = 1; end
            4'd6: begin w.alu_src_a = 2'b10; w.alu_control = exec_alu; end
            4'd7: begin w.alu_src_a = 2'b10; w.alu_src_b = 2'b01; w.alu_control = exec_alu; end
            4'd8: begin w.reg_write = 1; end
            4'd9: begin w.alu_src_a = 2'b10; w.alu_control = 3'b001; w.pc_write = beq_taken; end
            4'd10: begin w.alu_src_a = 2'b01; w.alu_src_b = 2'b10; w.pc_write = 1; end
            default: ;
        endcase
        return w;
    endfunction

    task automatic checkOutput(input entry_t e);
        ctrl_t act;
        act.state       = bus.o_state;
        act.pc_write    = bus.o_pcWrite;
        act.ir_write    = bus.o_irWrite;
        act.reg_write   = bus.o_regWrite;
        act.mem_write   = bus.o_memWrite;
        act.adr_src     = bus.o_adrSrc;
        act.result_src  = bus.o_resultSrc;
        act.alu_src_a   = bus.o_aluSrcA;
        act.alu_src_b   = bus.o_aluSrcB;
        act.alu_control = bus.o_aluControl;
        act.imm_src     = bus.o_immSrc;
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", e.tag, act, e.exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (scoreboard.size() > 0) checkOutput(scoreboard.pop_front());
        end
    end

    // Drives one instruction for its whole duration; seq holds states, first in the low nibble.
    task automatic applyStimulus(input string name, input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7b5, input logic zero, input logic [19:0] seq,
                                 input int n, input logic [2:0] exec_alu, input logic [1:0] imm);
        entry_t e;
        bus.i_op       = op;
        bus.i_funct3   = f3;
        bus.i_funct7b5 = f7b5;
        bus.i_zero     = zero;
        for (int i = 0; i < n; i++) begin
            e.tag = $sformatf("%s cycle%0d", name, i);
            e.exp = expected_word(seq[i*4 +: 4], exec_alu, zero, imm);
            scoreboard.push_back(e);
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushReset(input string name);
        entry_t e;
        e.tag = name;
        e.exp = expected_word(4'd0, 3'b000, 1'b0, bus.i_op == 7'b0100011 ? 2'b01 : 2'b00);
        e.exp.pc_write = 1'b0;
        e.exp.ir_write = 1'b0;
        scoreboard.push_back(e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_op = 7'b0000011;
        bus.i_funct3 = 3'b010;
        bus.i_funct7b5 = 1'b0;
        bus.i_zero = 1'b0;
        pushReset("reset_hold");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 5, 3'b000, 2'b00);
        applyStimulus("sw",      7'b0100011, 3'b010, 1'b0, 1'b0, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 4, 3'b000, 2'b01);
        applyStimulus("r_sub",   7'b0110011, 3'b000, 1'b1, 1'b0, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, 4, 3'b001, 2'b00);
        applyStimulus("r_add",   7'b0110011, 3'b000, 1'b0, 1'b0, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, 4, 3'b000, 2'b00);
        applyStimulus("r_slt",   7'b0110011, 3'b010, 1'b0, 1'b0, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, 4, 3'b101, 2'b00);
        applyStimulus("r_or",    7'b0110011, 3'b110, 1'b0, 1'b0, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, 4, 3'b011, 2'b00);
        applyStimulus("r_and",   7'b0110011, 3'b111, 1'b0, 1'b0, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, 4, 3'b010, 2'b00);
        applyStimulus("r_f3_1",  7'b0110011, 3'b001, 1'b1, 1'b0, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, 4, 3'b000, 2'b00);
        applyStimulus("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, {4'd0, 4'd8, 4'd7, 4'd1, 4'd0}, 4, 3'b000, 2'b00);
        applyStimulus("ori",     7'b0010011, 3'b110, 1'b0, 1'b0, {4'd0, 4'd8, 4'd7, 4'd1, 4'd0}, 4, 3'b011, 2'b00);
        applyStimulus("beq_tk",  7'b1100011, 3'b000, 1'b0, 1'b1, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 3, 3'b000, 2'b10);
        applyStimulus("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 3, 3'b000, 2'b10);
        applyStimulus("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, {4'd0, 4'd8, 4'd10, 4'd1, 4'd0}, 4, 3'b000, 2'b11);
        applyStimulus("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 2, 3'b000, 2'b00);

        // Abort an lw once it reaches MEMREAD: reset must pull the FSM back to FETCH with no writes.
        applyStimulus("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, {4'd0, 4'd0, 4'd2, 4'd1, 4'd0}, 3, 3'b000, 2'b00);
        rst = 1'b1;
        pushReset("reset_mid_lw");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("sw_after", 7'b0100011, 3'b010, 1'b0, 1'b0, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 4, 3'b000, 2'b01);

        @(negedge clk);
        #1;
        checks++;
        if (scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", scoreboard.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
